// File: rtl/aes_top_if.sv
// Block/result port bundle for the iterative AES-128 encryption core.
interface aes_top_if;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;

    modport master (output AES_en, AES_data_in, AES_key_in,
                    input  AES_data_out, AES_data_out_valid);
    modport slave  (input  AES_en, AES_data_in, AES_key_in,
                    output AES_data_out, AES_data_out_valid);
endinterface

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor, one round per clock, on-the-fly key expansion.
// AES_OUT_HOLD_EN: keep the last ciphertext on AES_data_out between valid pulses.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    // Entry 0 sits in the top byte, so invert the index to address it.
    assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_top (
    input  logic      AES_clk,
    input  logic      AES_rst_n,
    aes_top_if.slave  bus
);
    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         st, st_nx;
    logic [127:0] state_q, rkey_q, dout_q;
    logic [3:0]   round_q;
    logic         valid_q, capture, last_round;
    logic [127:0] sb, sr, mc, nkey, nstate;
    logic [31:0]  rot, sw, tmp, n0, n1, n2, n3;
    logic [7:0]   rcon;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) st <= IDLE;
        else            st <= st_nx;
    end

    always_comb begin
        st_nx      = st;
        capture    = 1'b0;
        last_round = 1'b0;
        case (st)
            IDLE: if (bus.AES_en) begin
                capture = 1'b1;
                st_nx   = RUN;
            end
            RUN: if (round_q == 4'd10) begin
                last_round = 1'b1;
                st_nx      = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    // Byte i of a block lives at [127-8i -: 8]; column c holds bytes 4c..4c+3.
    for (genvar g = 0; g < 16; g++) begin : g_sub
        aes_sbox u_sbox (.a(state_q[127-8*g -: 8]), .y(sb[127-8*g -: 8]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = sr[127-32*c -: 32];
        assign mc[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end

    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd1:  rcon = 8'h01;
            4'd2:  rcon = 8'h02;
            4'd3:  rcon = 8'h04;
            4'd4:  rcon = 8'h08;
            4'd5:  rcon = 8'h10;
            4'd6:  rcon = 8'h20;
            4'd7:  rcon = 8'h40;
            4'd8:  rcon = 8'h80;
            4'd9:  rcon = 8'h1b;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot = {rkey_q[23:0], rkey_q[31:24]};
    for (genvar k = 0; k < 4; k++) begin : g_ksub
        aes_sbox u_sbox (.a(rot[31-8*k -: 8]), .y(sw[31-8*k -: 8]));
    end

    assign tmp    = sw ^ {rcon, 24'h0};
    assign n0     = rkey_q[127:96] ^ tmp;
    assign n1     = rkey_q[95:64] ^ n0;
    assign n2     = rkey_q[63:32] ^ n1;
    assign n3     = rkey_q[31:0] ^ n2;
    assign nkey   = {n0, n1, n2, n3};
    assign nstate = (last_round ? sr : mc) ^ nkey;

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q <= '0;
            rkey_q  <= '0;
            dout_q  <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= last_round;
            if (capture) begin
                state_q <= bus.AES_data_in ^ bus.AES_key_in;
                rkey_q  <= bus.AES_key_in;
                round_q <= 4'd1;
            end else if (st == RUN) begin
                state_q <= nstate;
                rkey_q  <= nkey;
                round_q <= last_round ? 4'd0 : round_q + 4'd1;
                if (last_round) dout_q <= nstate;
            end
        end
    end

    assign bus.AES_data_out_valid = valid_q;
`ifdef AES_OUT_HOLD_EN
    assign bus.AES_data_out = dout_q;
`else
    assign bus.AES_data_out = valid_q ? dout_q : '0;
`endif
endmodule

// File: tb/tb_aes_top.sv
// Randomized scoreboard bench for aes_top against a byte-level AES-128 model.
module tb_aes_top;
    logic clk = 1'b0;
    logic rst_n;
    aes_top_if bus();

    aes_top dut (.AES_clk(clk), .AES_rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   sbox_tab[256];
    logic [127:0] last = '0;
    int checks = 0, errors = 0, cyc = 0, rem = 0, pulses = 0;
    logic prev_v = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w[44];
        logic [31:0]  t;
        logic [7:0]   s[16], u[16], rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) u[4*c+r] = sbox_tab[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                {a0, a1, a2, a3} = {u[4*c], u[4*c+1], u[4*c+2], u[4*c+3]};
                if (rnd < 10) begin
                    u[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    u[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    u[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    u[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
                for (int r = 0; r < 4; r++) s[4*c+r] = u[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference timing: a capture occupies the next ten edges, result due on the tenth.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            rem  = 0;
            last = '0;
        end else begin
            cyc++;
            if (rem > 0) rem--;
            else if (bus.AES_en) begin
                exp_q.push_back('{ct: ref_aes(bus.AES_data_in, bus.AES_key_in), due: cyc + 10});
                rem = 10;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.AES_data_out_valid) begin
                chk("valid_single_cycle", {127'h0, prev_v}, 128'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid with data %h, required no pulse",
                             bus.AES_data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("ciphertext", bus.AES_data_out, e.ct);
                    chk("latency_cycle", 128'(cyc), 128'(e.due));
                    last = e.ct;
                    pulses++;
                end
            end else begin
`ifdef AES_OUT_HOLD_EN
                chk("idle_hold", bus.AES_data_out, last);
`else
                chk("idle_zero", bus.AES_data_out, 128'h0);
`endif
            end
        end
        prev_v = bus.AES_data_out_valid;
    end

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rem != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key, input int hold);
        @(negedge clk);
        bus.AES_data_in = pt;
        bus.AES_key_in  = key;
        bus.AES_en      = 1'b1;
        repeat (hold) @(negedge clk);
        bus.AES_en = 1'b0;
    endtask

    initial begin
        logic [7:0] inv, x, y;
        int p0;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            x = inv;
            y = inv;
            for (int k = 0; k < 4; k++) begin
                x = {x[6:0], x[7]};
                y ^= x;
            end
            sbox_tab[a] = y ^ 8'h63;
        end

        rst_n = 1'b0;
        bus.AES_en = 1'b0;
        bus.AES_data_in = '0;
        bus.AES_key_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", {127'h0, bus.AES_data_out_valid}, 128'h0);
        chk("reset_data", bus.AES_data_out, 128'h0);
        rst_n = 1'b1;

        chk("model_fips_c1", ref_aes(128'h00112233445566778899aabbccddeeff,
            128'h000102030405060708090a0b0c0d0e0f), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("model_fips_b", ref_aes(128'h3243f6a8885a308d313198a2e0370734,
            128'h2b7e151628aed2a6abf7158809cf4f3c), 128'h3925841d02dc09fbdc118597196a0b32);

        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1);
        drain();
        send(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1);
        drain();

        // Continuous request: captures on edges 0, 11, 22, 33, 44 of the 51-cycle window.
        p0 = pulses;
        send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 51);
        drain();
        chk("hold_en_pulse_count", 128'(pulses - p0), 128'd5);

        // Inputs disturbed while a block is in flight.
        send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1);
        repeat (3) @(negedge clk);
        bus.AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        bus.AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
        bus.AES_en = 1'b1;
        @(negedge clk);
        bus.AES_en = 1'b0;
        drain();

        // Reset between round-4 and round-5 edges aborts the block silently.
        send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_valid", {127'h0, bus.AES_data_out_valid}, 128'h0);
        chk("midrun_reset_data", bus.AES_data_out, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1);
        drain();

        for (int i = 0; i < 20; i++) begin
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(1, 3));
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_top.md
# aes_top

Iterative AES-128 encryption core: captures one 128-bit plaintext block and 128-bit cipher key on a start request and computes one round per clock with on-the-fly key expansion. It presents the ciphertext with a one-cycle valid pulse. It is the top-level crypto datapath; surrounding logic supplies blocks and consumes results. Encryption only; no decryption path.

## Interface
- No parameters; key size fixed at 128 bits, 10 rounds.
- Clocking and reset: one clock; reset is asynchronous and active-low (AES_clk, AES_rst_n).
- AES_clk  in  1  rising-edge clock for all state.
- AES_rst_n  in  1  asynchronous active-low reset.
- AES_en  in  1  level start request; sampled only while idle.
- AES_data_in  in  128  plaintext; bits [127:120] = byte 0 (FIPS-197 column-major order).
- AES_key_in  in  128  cipher key; same byte ordering.
- AES_data_out  out  128  ciphertext, same byte ordering.
- AES_data_out_valid  out  1  one-cycle pulse; AES_data_out holds a new result.

## Operation
- States:
  - IDLE: waits for AES_en=1, then captures inputs and goes to RUN.
  - RUN: executes rounds 1..10, then returns to IDLE.
- Capture edge, in IDLE with AES_en=1:
  - state ← AES_data_in ^ AES_key_in.
  - round key ← AES_key_in.
  - round counter ← 1.
- Rounds 1–9: SubBytes, ShiftRows, MixColumns, AddRoundKey with the next expanded key.
- Round 10: omits MixColumns.
- Key expansion is combinational from the current round key each cycle:
  - RotWord, SubWord (4 S-boxes), Rcon XOR.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- S-box: standard AES forward S-box. 16 instances for the state plus 4 for the key schedule, combinational.
- MixColumns: GF(2^8) arithmetic with polynomial 0x11b (xtime = shift-left, conditional XOR 0x1b).
- Inputs are ignored during RUN. Changes to AES_data_in or AES_key_in, or AES_en dropping, do not affect the block in flight; it always completes.
- AES_en held high continuously: the core re-captures on the first idle cycle after each completion, so results repeat with identical inputs.
- Reset, whether mid-operation or idle:
  - Aborts any block in flight and returns to IDLE.
  - Clears the round counter and state.
  - AES_data_out ← 0, AES_data_out_valid ← 0.

## Timing
- Capture at edge T0. Rounds at edges T1..T10.
- AES_data_out is registered at T10. AES_data_out_valid is high for exactly the cycle T10–T11.
- Latency: 10 cycles from the capture edge to valid.
- Next capture earliest at T11, giving a throughput of one block per 11 cycles.
- Valid never stays high for more than one consecutive cycle.
- Reset values: AES_data_out = 128'h0, AES_data_out_valid = 0, state IDLE.

## Configuration
- AES_OUT_HOLD_EN defined:
  - AES_data_out keeps the last ciphertext until the next result or reset.
- AES_OUT_HOLD_EN undefined:
  - AES_data_out is forced to 128'h0 whenever AES_data_out_valid is 0, so the ciphertext is visible only during the valid cycle.
- Valid timing and latency are identical in both builds.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, AES_en pulsed one cycle.
  - Required: valid 10 cycles after capture with 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 Appendix B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: output 3925841d02dc09fbdc118597196a0b32.
- AES_en held high for 51 cycles with fixed inputs:
  - Required: valid pulses every 11 cycles, each carrying the same ciphertext; no extra block after AES_en drops except the one already in flight.
- Input changes mid-RUN:
  - Stimulus: change AES_data_in and AES_key_in, and drop AES_en, during RUN.
  - Required: the result equals the captured block's ciphertext.
- Reset during round 5:
  - Required: outputs 0 immediately, with no valid pulse.
  - Required: a new AES_en after reset produces the correct result.
- Reset and idle output values:
  - Required: after reset, outputs are 0.
  - Required: AES_data_out between valid pulses holds the last result with AES_OUT_HOLD_EN and is 0 without it.
